scan_input_conditioner: RTL and testbench

//  - Input-image stage feeding the executor: samples ui_in once per scan cycle, synchronises and

---
 rtl/scan_input_conditioner_pkg.sv | 29 ++
 rtl/scan_input_conditioner_debounce.sv | 55 +++++
 rtl/scan_input_conditioner.sv | 81 ++++++++
 tb/tb_scan_input_conditioner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/scan_input_conditioner_pkg.sv
// Shared types and constants for the scan input conditioner and its per-bit debounce slice.
// Optional macro SCAN_INPUT_FORCE_EN enables the force ports on the top level.
package scan_pkg;

  localparam int N_IN_DEF    = 8;
  localparam int DBC_W       = 4;
  localparam int PRIME_SCANS = 3;
  localparam int PRIME_W     = 2;

  typedef enum logic [1:0] {
    DBC_HOLD   = 2'd0,
    DBC_COUNT  = 2'd1,
    DBC_ACCEPT = 2'd2,
    DBC_BYPASS = 2'd3
  } dbc_act_e;

  typedef struct packed {
    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [DBC_W-1:0] cnt;
  } dbc_state_t;

  // Saturates once the sync pipeline and the previous image are known to be loaded.
  function automatic logic [PRIME_W-1:0] prime_next(input logic [PRIME_W-1:0] p);
    return (p == PRIME_W'(PRIME_SCANS)) ? p : p + PRIME_W'(1);
  endfunction

endpackage

// File: rtl/scan_input_conditioner_debounce.sv
// One input bit: two-flop synchroniser followed by a consecutive-scan debounce filter.
// Related top-level macro SCAN_INPUT_FORCE_EN does not affect this slice.
module input_debounce_bit
  import scan_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic scan_cycle_clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic filt_en_i,
  output logic level_o
);

  localparam logic [DBC_W-1:0] CNT_LAST = DBC_W'(DEBOUNCE_SCANS - 1);

  dbc_state_t st_q, st_d;
  dbc_act_e   act;

  always_comb begin
    act = DBC_HOLD;
    if (!filt_en_i)                    act = DBC_BYPASS;
    else if (st_q.sync2 == st_q.stable) act = DBC_HOLD;
    else if (st_q.cnt == CNT_LAST)      act = DBC_ACCEPT;
    else                                act = DBC_COUNT;
  end

  always_comb begin
    st_d       = st_q;
    st_d.sync1 = raw_i;
    st_d.sync2 = st_q.sync1;
    case (act)
      DBC_HOLD:   st_d.cnt = '0;
      DBC_COUNT:  st_d.cnt = st_q.cnt + DBC_W'(1);
      DBC_ACCEPT: begin
        st_d.stable = st_q.sync2;
        st_d.cnt    = '0;
      end
      default: begin
        st_d.stable = st_q.sync2;
        st_d.cnt    = '0;
      end
    endcase
  end

  always_ff @(posedge scan_cycle_clk) begin
    if (!rst_n) st_q <= '0;
    else        st_q <= st_d;
  end

  // A bypassed bit is taken straight from the synchroniser so it lands in the image
  // three scans after the raw change; stable still tracks it for a clean mask switch.
  assign level_o = filt_en_i ? st_q.stable : st_q.sync2;

endmodule

// File: rtl/scan_input_conditioner.sv
// Scan input image stage: per-bit sync/debounce, image + previous image, edge flags, scan count.
// Macro SCAN_INPUT_FORCE_EN adds force_mask/force_val ports that override the image per bit.
module scan_input_conditioner
  import scan_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3,
  parameter int N_IN           = N_IN_DEF
) (
  input  logic            scan_cycle_clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] ui_in,
  input  logic [N_IN-1:0] debounce_mask,
`ifdef SCAN_INPUT_FORCE_EN
  input  logic [N_IN-1:0] force_mask,
  input  logic [N_IN-1:0] force_val,
`endif
  output logic [N_IN-1:0] image_o,
  output logic [N_IN-1:0] image_prev_o,
  output logic [N_IN-1:0] rise_o,
  output logic [N_IN-1:0] fall_o,
  output logic            image_valid_o,
  output logic [15:0]     scan_count_o
);

  logic [N_IN-1:0]    level;
  logic [N_IN-1:0]    merged;
  logic [N_IN-1:0]    image_q, image_d;
  logic [N_IN-1:0]    prev_q, prev_d;
  logic [15:0]        scan_cnt_q, scan_cnt_d;
  logic [PRIME_W-1:0] prime_q, prime_d;
  logic               valid_q, valid_d;

  for (genvar i = 0; i < N_IN; i++) begin : g_bit
    input_debounce_bit #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_dbc (
      .scan_cycle_clk (scan_cycle_clk),
      .rst_n          (rst_n),
      .raw_i          (ui_in[i]),
      .filt_en_i      (debounce_mask[i]),
      .level_o        (level[i])
    );
  end

`ifdef SCAN_INPUT_FORCE_EN
  // Debounce keeps running under a forced bit, so release returns the filtered level at once.
  assign merged = (level & ~force_mask) | (force_val & force_mask);
`else
  assign merged = level;
`endif

  always_comb begin
    image_d    = merged;
    prev_d     = image_q;
    scan_cnt_d = scan_cnt_q + 16'd1;
    prime_d    = prime_next(prime_q);
    valid_d    = valid_q | (prime_q == PRIME_W'(PRIME_SCANS));
  end

  always_ff @(posedge scan_cycle_clk) begin
    if (!rst_n) begin
      image_q    <= '0;
      prev_q     <= '0;
      scan_cnt_q <= '0;
      prime_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      image_q    <= image_d;
      prev_q     <= prev_d;
      scan_cnt_q <= scan_cnt_d;
      prime_q    <= prime_d;
      valid_q    <= valid_d;
    end
  end

  assign image_o       = image_q;
  assign image_prev_o  = prev_q;
  assign rise_o        = image_q & ~prev_q;
  assign fall_o        = ~image_q & prev_q;
  assign image_valid_o = valid_q;
  assign scan_count_o  = scan_cnt_q;

endmodule

// File: tb/tb_scan_input_conditioner.sv
// Randomised and directed bench for scan_input_conditioner against a window-based reference model.
// Force-port scenario is exercised only when SCAN_INPUT_FORCE_EN is defined.
module tb_scan_input_conditioner;

  localparam int N = 8;
  localparam int D = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  ui, mask;
  logic [N-1:0]  img, prv, rise, fall;
  logic          vld;
  logic [15:0]   cnt;
`ifdef SCAN_INPUT_FORCE_EN
  logic [N-1:0]  fm, fv;
`endif

  always #5 clk = ~clk;

  scan_input_conditioner #(.DEBOUNCE_SCANS(D), .N_IN(N)) dut (
    .scan_cycle_clk (clk),
    .rst_n          (rst_n),
    .ui_in          (ui),
    .debounce_mask  (mask),
`ifdef SCAN_INPUT_FORCE_EN
    .force_mask     (fm),
    .force_val      (fv),
`endif
    .image_o        (img),
    .image_prev_o   (prv),
    .rise_o         (rise),
    .fall_o         (fall),
    .image_valid_o  (vld),
    .scan_count_o   (cnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit do_chk = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a filtered bit flips once the last D synchronised samples all
  // disagree with its accepted level; bypassed bits take the sample directly.
  logic [N-1:0] m_s1, m_s2, m_stab, m_img, m_prev;
  logic [15:0]  m_cnt;
  int           m_edges;
  logic [N-1:0] hist[$];

  task automatic model_edge();
    logic [N-1:0] s2o, lvl, ns, h;
    bit flip;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_img = '0; m_prev = '0;
      m_cnt = '0; m_edges = 0; hist.delete();
    end else begin
      s2o = m_s2;
      lvl = (mask & m_stab) | (~mask & s2o);
`ifdef SCAN_INPUT_FORCE_EN
      lvl = (lvl & ~fm) | (fv & fm);
`endif
      hist.push_back(s2o);
      if (hist.size() > 16) void'(hist.pop_front());
      ns = m_stab;
      for (int i = 0; i < N; i++) begin
        if (!mask[i]) ns[i] = s2o[i];
        else if (hist.size() >= D) begin
          flip = 1'b1;
          for (int k = 1; k <= D; k++) begin
            h = hist[hist.size() - k];
            if (h[i] == m_stab[i]) flip = 1'b0;
          end
          if (flip) ns[i] = ~m_stab[i];
        end
      end
      m_stab = ns;
      m_prev = m_img;
      m_img  = lvl;
      m_s2   = m_s1;
      m_s1   = ui;
      m_cnt  = m_cnt + 16'd1;
      if (m_edges < 100) m_edges++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (do_chk) begin
      chk("image",  32'(img),  32'(m_img));
      chk("prev",   32'(prv),  32'(m_prev));
      chk("rise",   32'(rise), 32'(m_img & ~m_prev));
      chk("fall",   32'(fall), 32'(~m_img & m_prev));
      chk("valid",  32'(vld),  32'(m_edges >= 4));
      chk("count",  32'(cnt),  32'(m_cnt));
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  int rises;

  initial begin
    rst_n = 1'b0; ui = '0; mask = '1;
`ifdef SCAN_INPUT_FORCE_EN
    fm = '0; fv = '0;
`endif
    m_s1 = '0; m_s2 = '0; m_stab = '0; m_img = '0; m_prev = '0; m_cnt = '0; m_edges = 0;

    // 1: reset with inputs high, then valid on the 4th edge
    ui = 8'hFF;
    do_reset(2);
    chk("rst_image", 32'(img), 32'h0);
    chk("rst_cnt",   32'(cnt), 32'h0);
    repeat (3) step();
    chk("valid_3rd", 32'(vld), 32'h0);
    step();
    chk("valid_4th", 32'(vld), 32'h1);
    chk("count_4",   32'(cnt), 32'd4);

    // 2: filtered rising edge lands on the 6th edge, single-scan rise
    ui = '0; do_reset(1); repeat (8) step();
    ui[0] = 1'b1;
    rises = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 5) chk("b0_e5", 32'(img[0]), 32'h0);
      if (e == 6) chk("b0_e6", 32'(img[0]), 32'h1);
      rises += int'(rise[0]);
    end
    chk("b0_rises", 32'(rises), 32'd1);

    // 3: two-scan glitch is rejected
    ui[1] = 1'b1; repeat (2) step(); ui[1] = 1'b0;
    rises = 0;
    for (int e = 0; e < 10; e++) begin
      step();
      rises += int'(rise[1]) + int'(img[1]);
    end
    chk("glitch", 32'(rises), 32'd0);

    // 4: bypassed bit toggling each scan follows three edges late
    mask = 8'hFB;
    rises = 0;
    for (int e = 0; e < 12; e++) begin
      ui[2] = ~ui[2];
      step();
      rises += int'(rise[2]);
    end
    chk("bypass_rises", 32'(rises), 32'd5);

`ifdef SCAN_INPUT_FORCE_EN
    // 5: force sets bit 7 next edge, release clears it next edge
    ui = '0; mask = '1; repeat (8) step();
    fm = 8'h80; fv = 8'h80; step();
    chk("force_img",  32'(img[7]),  32'h1);
    chk("force_rise", 32'(rise[7]), 32'h1);
    fm = '0; step();
    chk("rel_img",  32'(img[7]),  32'h0);
    chk("rel_fall", 32'(fall[7]), 32'h1);
    fv = '0;
`endif

    // 6: reset mid-debounce discards the partial count
    ui = '0; mask = '1; do_reset(1); repeat (6) step();
    ui[3] = 1'b1; repeat (4) step();
    do_reset(1);
    chk("mid_rst_img", 32'(img), 32'h0);
    ui = '0; repeat (6) step();
    chk("mid_rst_b3", 32'(img[3]), 32'h0);

    // Randomised mix of inputs, masks and occasional resets
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) ui[i] = ~ui[i];
      if ($urandom_range(49) == 0) mask = N'($urandom);
`ifdef SCAN_INPUT_FORCE_EN
      if ($urandom_range(29) == 0) begin fm = N'($urandom); fv = N'($urandom); end
`endif
      rst_n = ($urandom_range(199) != 0);
      step();
    end
    rst_n = 1'b1;

    // Scan counter wrap
    do_reset(1);
    do_chk = 1'b0;
    repeat (65535) step();
    do_chk = 1'b1;
    step();
    chk("wrap", 32'(cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
